// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO family.
// Mode selection and count-width sizing.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Width needed to hold the values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// Read is read-before-write on an address collision.
module fifo_ram #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Registered read port with synchronous clear of the output register.
    always_ff @(posedge clk) begin
        if (n_reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO: pointers, occupancy, flags, sticky errors.
// FWFT mode uses the RAM read register as the prefetch stage.
module fifo_sync_ctrl
    import fifo_pkg::*;
#(
    parameter int  DATA_W = 24,
    parameter int  DEPTH  = 16,
    parameter int  FWFT   = 0,
    localparam int CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic [CNT_W-1:0]  afull_thr,
    input  logic [CNT_W-1:0]  aempty_thr,
    input  logic              clr_err,
    output logic [CNT_W-1:0]  data_count,
    output logic              empty,
    output logic              full,
    output logic              almst_empty,
    output logic              almst_full,
    output logic              overflow,
    output logic              underflow
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam fifo_mode_e       MODE    = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ram_cnt;
    logic             pv_q, pv_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             aempty_q, aempty_d;
    logic             afull_q, afull_d;
    logic             dv_q, dv_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             rd_acc, wr_acc, ram_re;

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PTR_W)
    ) u_ram (
        .clk     (clk),
        .n_reset (n_reset),
        .we_i    (wr_acc),
        .waddr_i (wptr_q),
        .wdata_i (data_in),
        .re_i    (ram_re),
        .raddr_i (rptr_q),
        .rdata_o (data_out)
    );

    // Accept decisions, prefetch control and next-state count/flags.
    always_comb begin
        rd_acc  = rd_en & ~empty_q;
        wr_acc  = wr_en & (~full_q | rd_acc);
        ram_cnt = cnt_q - CNT_W'(pv_q);
        ram_re  = rd_acc;
        pv_d    = 1'b0;
        if (MODE == FIFO_FWFT) begin
            ram_re = (ram_cnt != '0) & (~pv_q | rd_acc);
            pv_d   = ram_re | (pv_q & ~rd_acc);
        end

        wptr_d = wptr_q;
        if (wr_acc) begin
            wptr_d = (wptr_q == PTR_MAX) ? '0 : wptr_q + PTR_W'(1);
        end
        rptr_d = rptr_q;
        if (ram_re) begin
            rptr_d = (rptr_q == PTR_MAX) ? '0 : rptr_q + PTR_W'(1);
        end

        cnt_d = cnt_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        full_d   = (cnt_d == CNT_MAX);
        empty_d  = (MODE == FIFO_FWFT) ? ~pv_d : (cnt_d == '0);
        afull_d  = (cnt_d >= afull_thr);
        aempty_d = (cnt_d <= aempty_thr);
        dv_d     = (MODE == FIFO_FWFT) ? pv_d : rd_acc;
        ovf_d    = (wr_en & ~wr_acc) | (ovf_q & ~clr_err);
        udf_d    = (rd_en & ~rd_acc) | (udf_q & ~clr_err);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (n_reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            pv_q     <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            dv_q     <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            pv_q     <= pv_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            aempty_q <= aempty_d;
            afull_q  <= afull_d;
            dv_q     <= dv_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign data_valid  = dv_q;
    assign data_count  = cnt_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almst_empty = aempty_q;
    assign almst_full  = afull_q;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed bench: standard-mode DEPTH=5 and FWFT-mode DEPTH=8 instances.
// Expected values are hand-computed constants in the stimulus.
module tb_fifo_sync_ctrl;

    localparam int DW = 24;

    logic clk = 1'b0;
    logic n_reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Standard-mode instance, DEPTH=5 (CNT_W=3)
    logic          s_wr, s_rd, s_clr;
    logic [DW-1:0] s_din, s_dout;
    logic [2:0]    s_afthr, s_aethr, s_cnt;
    logic          s_dv, s_empty, s_full, s_ae, s_af, s_ovf, s_udf;

    // FWFT instance, DEPTH=8 (CNT_W=4)
    logic          f_wr, f_rd, f_clr;
    logic [DW-1:0] f_din, f_dout;
    logic [3:0]    f_afthr, f_aethr, f_cnt;
    logic          f_dv, f_empty, f_full, f_ae, f_af, f_ovf, f_udf;

    fifo_sync_ctrl #(.DATA_W(DW), .DEPTH(5), .FWFT(0)) u_std (
        .clk(clk), .n_reset(n_reset),
        .wr_en(s_wr), .data_in(s_din), .rd_en(s_rd),
        .data_out(s_dout), .data_valid(s_dv),
        .afull_thr(s_afthr), .aempty_thr(s_aethr), .clr_err(s_clr),
        .data_count(s_cnt), .empty(s_empty), .full(s_full),
        .almst_empty(s_ae), .almst_full(s_af),
        .overflow(s_ovf), .underflow(s_udf)
    );

    fifo_sync_ctrl #(.DATA_W(DW), .DEPTH(8), .FWFT(1)) u_fw (
        .clk(clk), .n_reset(n_reset),
        .wr_en(f_wr), .data_in(f_din), .rd_en(f_rd),
        .data_out(f_dout), .data_valid(f_dv),
        .afull_thr(f_afthr), .aempty_thr(f_aethr), .clr_err(f_clr),
        .data_count(f_cnt), .empty(f_empty), .full(f_full),
        .almst_empty(f_ae), .almst_full(f_af),
        .overflow(f_ovf), .underflow(f_udf)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge; return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_reset = 1'b1;
        s_wr = 0; s_rd = 0; s_clr = 0; s_din = '0;
        f_wr = 0; f_rd = 0; f_clr = 0; f_din = '0;
        s_afthr = 3'd4; s_aethr = 3'd1;
        f_afthr = 4'd4; f_aethr = 4'd1;
        @(negedge clk);
        tick();
        tick();

        // Reset state
        check("rst_cnt", 32'(s_cnt), 0);
        check("rst_empty", 32'(s_empty), 1);
        check("rst_full", 32'(s_full), 0);
        check("rst_ae", 32'(s_ae), 1);
        check("rst_af", 32'(s_af), 0);
        check("rst_dout", 32'(s_dout), 0);
        check("rst_dv", 32'(s_dv), 0);
        check("rst_ovf", 32'(s_ovf), 0);
        check("rst_udf", 32'(s_udf), 0);
        check("rst_f_empty", 32'(f_empty), 1);
        check("rst_f_cnt", 32'(f_cnt), 0);
        n_reset = 1'b0;
        tick();

        // 1: fill to full, overflow, drain
        for (int i = 1; i <= 5; i++) begin
            s_wr = 1; s_din = DW'(i);
            tick();
            check("t1_cnt", 32'(s_cnt), 32'(i));
            check("t1_full", 32'(s_full), (i == 5) ? 1 : 0);
            check("t1_af", 32'(s_af), (i >= 4) ? 1 : 0);
        end
        s_din = 24'h06;
        tick();
        s_wr = 0;
        check("t1_ovf", 32'(s_ovf), 1);
        check("t1_ovf_cnt", 32'(s_cnt), 5);
        s_clr = 1;
        tick();
        s_clr = 0;
        check("t1_clr", 32'(s_ovf), 0);
        for (int i = 1; i <= 5; i++) begin
            s_rd = 1;
            tick();
            check("t1_rd", 32'(s_dout), 32'(i));
            check("t1_dv", 32'(s_dv), 1);
        end
        s_rd = 0;
        check("t1_empty", 32'(s_empty), 1);
        check("t1_cnt0", 32'(s_cnt), 0);
        tick();
        check("t1_dv_lo", 32'(s_dv), 0);
        check("t1_hold", 32'(s_dout), 5);

        // 2: wrap pointers with 3-in/3-out bursts
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) begin
                s_wr = 1; s_din = DW'(8'h10 + 3 * r + k);
                tick();
            end
            s_wr = 0;
            for (int k = 0; k < 3; k++) begin
                s_rd = 1;
                tick();
                check("t2_rd", 32'(s_dout), 32'(8'h10 + 3 * r + k));
            end
            s_rd = 0;
        end
        check("t2_ovf", 32'(s_ovf), 0);
        check("t2_udf", 32'(s_udf), 0);
        check("t2_empty", 32'(s_empty), 1);

        // 3: simultaneous read/write while full
        for (int i = 0; i < 5; i++) begin
            s_wr = 1; s_din = DW'(8'h20 + i);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            s_wr = 1; s_rd = 1; s_din = DW'(8'h25 + i);
            tick();
            check("t3_rd", 32'(s_dout), 32'(8'h20 + i));
            check("t3_cnt", 32'(s_cnt), 5);
            check("t3_full", 32'(s_full), 1);
        end
        s_wr = 0;
        check("t3_ovf", 32'(s_ovf), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_drain", 32'(s_dout), 32'(8'h23 + i));
        end
        s_rd = 0;
        check("t3_empty", 32'(s_empty), 1);

        // 4: FWFT single word latency and pop
        f_wr = 1; f_din = 24'hABCDEF;
        tick();
        f_wr = 0;
        check("t4_cnt1", 32'(f_cnt), 1);
        check("t4_empty_pend", 32'(f_empty), 1);
        tick();
        check("t4_empty", 32'(f_empty), 0);
        check("t4_dout", 32'(f_dout), 32'h00ABCDEF);
        check("t4_dv", 32'(f_dv), 1);
        f_rd = 1;
        tick();
        f_rd = 0;
        check("t4_empty2", 32'(f_empty), 1);
        check("t4_cnt0", 32'(f_cnt), 0);
        check("t4_udf", 32'(f_udf), 0);

        // 5: thresholds, back-to-back FWFT reads
        for (int i = 0; i < 4; i++) begin
            f_wr = 1; f_din = DW'(8'h30 + i);
            tick();
            check("t5_cnt", 32'(f_cnt), 32'(i + 1));
            check("t5_af", 32'(f_af), (i == 3) ? 1 : 0);
            check("t5_ae", 32'(f_ae), (i == 0) ? 1 : 0);
        end
        f_wr = 0;
        check("t5_head", 32'(f_dout), 32'h30);
        for (int i = 1; i <= 3; i++) begin
            f_rd = 1;
            tick();
            check("t5_b2b", 32'(f_dout), 32'(8'h30 + i));
            check("t5_dv", 32'(f_dv), 1);
        end
        f_rd = 0;
        check("t5_cnt1", 32'(f_cnt), 1);
        check("t5_ae1", 32'(f_ae), 1);
        for (int i = 0; i < 2; i++) begin
            f_wr = 1; f_din = DW'(8'h34 + i);
            tick();
        end
        f_wr = 0;
        check("t5_cnt3", 32'(f_cnt), 3);
        check("t5_af_lo", 32'(f_af), 0);
        f_afthr = 4'd2;
        tick();
        check("t5_af_thr", 32'(f_af), 1);
        check("t5_hold", 32'(f_dout), 32'h33);

        // 6: underflow, clear, set-wins, mid-fill reset
        s_rd = 1;
        tick();
        check("t6_udf", 32'(s_udf), 1);
        check("t6_dv", 32'(s_dv), 0);
        s_rd = 0; s_clr = 1;
        tick();
        check("t6_clr", 32'(s_udf), 0);
        s_rd = 1;
        tick();
        check("t6_setwins", 32'(s_udf), 1);
        s_rd = 0;
        tick();
        s_clr = 0;
        for (int i = 0; i < 3; i++) begin
            s_wr = 1; s_din = DW'(8'h40 + i);
            tick();
        end
        s_wr = 0;
        check("t6_cnt3", 32'(s_cnt), 3);
        n_reset = 1;
        tick();
        n_reset = 0;
        check("t6_rst_cnt", 32'(s_cnt), 0);
        check("t6_rst_empty", 32'(s_empty), 1);
        s_rd = 1;
        tick();
        s_rd = 0;
        check("t6_post_udf", 32'(s_udf), 1);
        check("t6_post_cnt", 32'(s_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
